coralnpu_irq_arbiter: RTL and testbench
=======================================

CORALNPU_IRQ_ARBITER -- requirements
Module: coralnpu_irq_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_SRC, default 8, number of interrupt sources (2..32).
REQ-002 The block SHALL have parameter ID_W, default $clog2(NUM_SRC), width of source ids.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-004 The block SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 The block SHALL have port src, input, NUM_SRC, raw interrupt sources, synchronous to clk.
REQ-006 The block SHALL have port src_en, input, NUM_SRC, per-source enable mask; 1 = eligible.
REQ-007 The block SHALL have port src_edge, input, NUM_SRC, per-source mode; 1 = rising-edge, 0 = level.
REQ-008 The block SHALL have port halted, input, 1, core-halted status.
REQ-009 The block SHALL have port fault, input, 1, core-fault status.
REQ-010 The block SHALL have port wfi, input, 1, core in wait-for-interrupt.
REQ-011 The block SHALL have port irq, output, 1, registered interrupt request to core irq input.
REQ-012 The block SHALL have port claim, input, 1, one-cycle pulse: core accepts the current claim_id.
REQ-013 The block SHALL have port claim_id, output, ID_W, registered winning source id.
REQ-014 The block SHALL have port complete, input, 1, one-cycle pulse: handler done.
REQ-015 The block SHALL have port complete_id, input, ID_W, id being completed.
REQ-016 The block SHALL have port busy, output, 1, high while a source is in service.
REQ-017 The block SHALL have port pending, output, NUM_SRC, registered pending vector.
REQ-018 The block SHALL have port wake, output, 1, registered: wfi high and any eligible pending bit.
REQ-019 The block SHALL have port err, output, 1, sticky protocol-error flag.

Function
REQ-020 Edge sources SHALL set pending[i] the cycle after src[i] samples 0 then 1 (prev-sample register).
REQ-021 Level sources SHALL have pending[i] = registered src[i]; claim does not clear level bits.
REQ-022 An edge pending bit SHALL clear only on claim with claim_id==i; a new edge in the same cycle wins (stays set).
REQ-023 Eligible vector SHALL = pending & src_en, excluding the in-service id.
REQ-024 Priority SHALL be fixed: lowest eligible index wins; claim_id updates every cycle in ASSERT.
REQ-025 FSM SHALL have states IDLE, ASSERT, SERVICE; reset enters IDLE.
REQ-026 IDLE -> ASSERT when eligible != 0 and halted==0 and fault==0.
REQ-027 ASSERT -> SERVICE on claim; in-service id latched = claim_id; irq low the next cycle.
REQ-028 ASSERT -> IDLE, irq low next cycle, when eligible becomes 0 or halted or fault rises.
REQ-029 SERVICE -> IDLE on complete with complete_id == in-service id; eligible re-evaluated from IDLE next cycle.
REQ-030 irq SHALL be 1 exactly while state==ASSERT; busy exactly while state==SERVICE.
REQ-031 Latency: edge at src sample cycle N -> pending at N+1 -> irq at N+2.
REQ-032 claim outside ASSERT, complete outside SERVICE, or complete_id mismatch SHALL be ignored and set err.
REQ-033 Claim and complete in the same cycle: claim processed per state; complete judged against state before the edge.
REQ-034 fault SHALL not alter pending or SERVICE; only blocks/abandons ASSERT.
REQ-035 src_en deassert does not clear pending; re-enable makes the bit eligible again.

Reset
REQ-036 During reset: state IDLE, irq=0, busy=0, wake=0, err=0, claim_id=0, pending=0, prev-sample=0.
REQ-037 Reset mid-ASSERT or mid-SERVICE SHALL abandon in-service id; first post-reset cycle irq=0.
REQ-038 err SHALL clear only by reset.

Verification
REQ-039 Edge src[3] pulse at cycle 10, all enabled -> pending[3]=1 @11, irq=1 @12, claim_id=3; claim @14 -> irq=0, busy=1, pending[3]=0 @15.
REQ-040 Edge src[5] and src[2] same cycle -> claim_id=2 first; complete(2) -> IDLE, then ASSERT with claim_id=5.
REQ-041 Level src[0]=1 held, claim then complete(0) -> irq re-asserts two cycles after complete.
REQ-042 ASSERT with fault rising -> irq=0 next cycle, pending kept; fault low -> irq returns.
REQ-043 complete_id=4 while servicing 1 -> state stays SERVICE, err=1 sticky; reset -> err=0.
REQ-044 wfi=1, src_en[6]=0, edge on src[6] -> wake=0; set src_en[6]=1 -> wake=1 next cycle.

Source files
------------

// File: rtl/coralnpu_irq_arbiter.sv
// Interrupt arbiter for the CoralNPU core.
// Collects edge- or level-mode sources into a pending vector, picks the lowest
// eligible index and drives a single registered irq with a claim/complete handshake.
// A three-state FSM (idle / asserting / in service) owns irq and busy; protocol
// misuse raises a sticky err that only reset clears.
module coralnpu_irq_arbiter #(
  parameter int unsigned NUM_SRC = 8,
  parameter int unsigned ID_W    = $clog2(NUM_SRC)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src,
  input  logic [NUM_SRC-1:0] src_en,
  input  logic [NUM_SRC-1:0] src_edge,
  input  logic               halted,
  input  logic               fault,
  input  logic               wfi,
  output logic               irq,
  input  logic               claim,
  output logic [ID_W-1:0]    claim_id,
  input  logic               complete,
  input  logic [ID_W-1:0]    complete_id,
  output logic               busy,
  output logic [NUM_SRC-1:0] pending,
  output logic               wake,
  output logic               err
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StAssert  = 2'd1,
    StService = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [NUM_SRC-1:0] src_prev_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [ID_W-1:0]    claim_id_q, claim_id_d;
  logic [ID_W-1:0]    insvc_q, insvc_d;
  logic               wake_q, wake_d;
  logic               err_q, err_d;

  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] claim_clr;
  logic [NUM_SRC-1:0] insvc_mask;
  logic [NUM_SRC-1:0] eligible;
  logic [ID_W-1:0]    winner;
  logic               any_elig;
  logic               claim_ok;
  logic               complete_ok;

  // A claim only counts while asserting; a complete only while servicing that id.
  assign claim_ok    = claim && (state_q == StAssert);
  assign complete_ok = complete && (state_q == StService) && (complete_id == insvc_q);

  // Per-source decode: rising edges, claim clear targets and the in-service mask.
  always_comb begin
    rise       = src & ~src_prev_q;
    claim_clr  = '0;
    insvc_mask = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      claim_clr[i]  = claim_ok && (claim_id_q == ID_W'(i));
      insvc_mask[i] = (state_q == StService) && (insvc_q == ID_W'(i));
    end
  end

  // Next pending vector: level bits follow src, edge bits latch until claimed.
  always_comb begin
    pending_d = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_edge[i]) begin
        // A fresh edge in the claim cycle keeps the bit set.
        pending_d[i] = (pending_q[i] && !claim_clr[i]) || rise[i];
      end else begin
        pending_d[i] = src[i];
      end
    end
  end

  // Eligibility and fixed lowest-index-first priority.
  always_comb begin
    eligible = pending_q & src_en & ~insvc_mask;
    any_elig = |eligible;
    winner   = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winner = ID_W'(i);
      end
    end
  end

  // FSM next state plus the claim id and in-service id that ride along with it.
  always_comb begin
    state_d    = state_q;
    claim_id_d = claim_id_q;
    insvc_d    = insvc_q;
    unique case (state_q)
      StIdle: begin
        if (any_elig && !halted && !fault) begin
          state_d    = StAssert;
          claim_id_d = winner;
        end
      end
      StAssert: begin
        if (claim) begin
          // Claim wins over a same-cycle abandon; the core already took the id.
          state_d = StService;
          insvc_d = claim_id_q;
        end else if (!any_elig || halted || fault) begin
          state_d = StIdle;
        end else begin
          claim_id_d = winner;
        end
      end
      StService: begin
        if (complete_ok) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Registered side outputs: wake request and sticky protocol error.
  always_comb begin
    wake_d = wfi && any_elig;
    err_d  = err_q
           || (claim && (state_q != StAssert))
           || (complete && !complete_ok);
  end

  // All state, synchronously reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      src_prev_q <= '0;
      pending_q  <= '0;
      claim_id_q <= '0;
      insvc_q    <= '0;
      wake_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_prev_q <= src;
      pending_q  <= pending_d;
      claim_id_q <= claim_id_d;
      insvc_q    <= insvc_d;
      wake_q     <= wake_d;
      err_q      <= err_d;
    end
  end

  assign irq      = (state_q == StAssert);
  assign busy     = (state_q == StService);
  assign claim_id = claim_id_q;
  assign pending  = pending_q;
  assign wake     = wake_q;
  assign err      = err_q;

endmodule

// File: tb/tb_coralnpu_irq_arbiter.sv
// Bench for coralnpu_irq_arbiter: directed scenarios followed by randomized traffic,
// every cycle compared against a behavioural model of the arbiter rules.
module tb_coralnpu_irq_arbiter;

  localparam int NUM = 8;
  localparam int IDW = 3;
  localparam int M_IDLE = 0;
  localparam int M_ASSERT = 1;
  localparam int M_SERVICE = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [NUM-1:0] src = '0;
  logic [NUM-1:0] src_en = '1;
  logic [NUM-1:0] src_edge = '1;
  logic           halted = 1'b0;
  logic           fault = 1'b0;
  logic           wfi = 1'b0;
  logic           irq;
  logic           claim = 1'b0;
  logic [IDW-1:0] claim_id;
  logic           complete = 1'b0;
  logic [IDW-1:0] complete_id = '0;
  logic           busy;
  logic [NUM-1:0] pending;
  logic           wake;
  logic           err;

  int n_checks = 0;
  int n_fail = 0;

  // Behavioural model state
  int m_state = M_IDLE;
  int m_cid = 0;
  int m_insvc = 0;
  bit m_err = 1'b0;
  bit m_wake = 1'b0;
  bit m_pend[NUM];
  bit m_prev[NUM];

  coralnpu_irq_arbiter #(
    .NUM_SRC(NUM),
    .ID_W   (IDW)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .src        (src),
    .src_en     (src_en),
    .src_edge   (src_edge),
    .halted     (halted),
    .fault      (fault),
    .wfi        (wfi),
    .irq        (irq),
    .claim      (claim),
    .claim_id   (claim_id),
    .complete   (complete),
    .complete_id(complete_id),
    .busy       (busy),
    .pending    (pending),
    .wake       (wake),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs the DUT sees at this edge.
  task automatic model_step();
    int  win;
    bit  taken;
    bit  n_pend[NUM];
    if (reset) begin
      m_state = M_IDLE;
      m_cid   = 0;
      m_insvc = 0;
      m_err   = 1'b0;
      m_wake  = 1'b0;
      for (int i = 0; i < NUM; i++) begin
        m_pend[i] = 1'b0;
        m_prev[i] = 1'b0;
      end
      return;
    end
    win = -1;
    for (int i = 0; i < NUM; i++) begin
      if (win < 0 && m_pend[i] && src_en[i] && !(m_state == M_SERVICE && m_insvc == i)) win = i;
    end
    taken = claim && (m_state == M_ASSERT);
    if (claim && m_state != M_ASSERT) m_err = 1'b1;
    if (complete && !(m_state == M_SERVICE && int'(complete_id) == m_insvc)) m_err = 1'b1;
    for (int i = 0; i < NUM; i++) begin
      if (src_edge[i]) begin
        if (src[i] && !m_prev[i]) n_pend[i] = 1'b1;
        else if (taken && m_cid == i) n_pend[i] = 1'b0;
        else n_pend[i] = m_pend[i];
      end else begin
        n_pend[i] = src[i];
      end
    end
    m_wake = wfi && (win >= 0);
    case (m_state)
      M_IDLE: begin
        if (win >= 0 && !halted && !fault) begin
          m_state = M_ASSERT;
          m_cid   = win;
        end
      end
      M_ASSERT: begin
        if (claim) begin
          m_state = M_SERVICE;
          m_insvc = m_cid;
        end else if (win < 0 || halted || fault) begin
          m_state = M_IDLE;
        end else begin
          m_cid = win;
        end
      end
      default: begin
        if (complete && int'(complete_id) == m_insvc) m_state = M_IDLE;
      end
    endcase
    for (int i = 0; i < NUM; i++) begin
      m_pend[i] = n_pend[i];
      m_prev[i] = src[i];
    end
  endtask

  task automatic compare_all();
    logic [NUM-1:0] exp_pend;
    for (int i = 0; i < NUM; i++) exp_pend[i] = m_pend[i];
    check_eq("irq", 32'(irq), 32'(m_state == M_ASSERT));
    check_eq("busy", 32'(busy), 32'(m_state == M_SERVICE));
    check_eq("claim_id", 32'(claim_id), 32'(m_cid));
    check_eq("pending", 32'(pending), 32'(exp_pend));
    check_eq("wake", 32'(wake), 32'(m_wake));
    check_eq("err", 32'(err), 32'(m_err));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic do_claim();
    claim = 1'b1;
    tick();
    claim = 1'b0;
  endtask

  task automatic do_complete(input int id);
    complete    = 1'b1;
    complete_id = IDW'(id);
    tick();
    complete    = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check_eq("rst_irq", 32'(irq), 32'd0);
    check_eq("rst_pending", 32'(pending), 32'd0);
    check_eq("rst_claim_id", 32'(claim_id), 32'd0);
    reset = 1'b0;
    tick();

    // Single edge source: pending, irq latency, claim clears edge bit
    src = 8'h08;
    tick();
    check_eq("e3_pending", 32'(pending[3]), 32'd1);
    check_eq("e3_irq_early", 32'(irq), 32'd0);
    src = 8'h00;
    tick();
    check_eq("e3_irq", 32'(irq), 32'd1);
    check_eq("e3_claim_id", 32'(claim_id), 32'd3);
    tick();
    do_claim();
    check_eq("e3_irq_after_claim", 32'(irq), 32'd0);
    check_eq("e3_busy", 32'(busy), 32'd1);
    check_eq("e3_pending_clr", 32'(pending[3]), 32'd0);
    do_complete(3);
    check_eq("e3_done", 32'(busy), 32'd0);

    // Two simultaneous edges: lowest index first
    src = 8'h24;
    tick();
    src = 8'h00;
    tick();
    check_eq("pri_first", 32'(claim_id), 32'd2);
    do_claim();
    do_complete(2);
    check_eq("pri_idle", 32'(irq), 32'd0);
    tick();
    check_eq("pri_second_irq", 32'(irq), 32'd1);
    check_eq("pri_second", 32'(claim_id), 32'd5);
    do_claim();
    do_complete(5);

    // Held level source re-asserts two cycles after complete
    src_edge = 8'hfe;
    src = 8'h01;
    tick();
    tick();
    check_eq("lvl_irq", 32'(irq), 32'd1);
    do_claim();
    check_eq("lvl_pending_kept", 32'(pending[0]), 32'd1);
    do_complete(0);
    check_eq("lvl_gap", 32'(irq), 32'd0);
    tick();
    check_eq("lvl_reassert", 32'(irq), 32'd1);
    src = 8'h00;
    tick();
    tick();
    src_edge = 8'hff;
    tick();

    // Fault abandons assert but keeps pending
    src = 8'h02;
    tick();
    src = 8'h00;
    tick();
    check_eq("flt_irq", 32'(irq), 32'd1);
    fault = 1'b1;
    tick();
    check_eq("flt_drop", 32'(irq), 32'd0);
    check_eq("flt_pending", 32'(pending[1]), 32'd1);
    fault = 1'b0;
    tick();
    check_eq("flt_return", 32'(irq), 32'd1);
    do_claim();
    check_eq("pre_err", 32'(err), 32'd0);

    // Wrong complete id while servicing 1
    do_complete(4);
    check_eq("cid_busy", 32'(busy), 32'd1);
    check_eq("cid_err", 32'(err), 32'd1);
    tick();
    check_eq("cid_err_sticky", 32'(err), 32'd1);
    do_complete(1);
    reset = 1'b1;
    tick();
    check_eq("cid_err_rst", 32'(err), 32'd0);
    reset = 1'b0;

    // Wake gated by enable
    wfi = 1'b1;
    src_en = 8'hbf;
    src = 8'h40;
    tick();
    src = 8'h00;
    tick();
    check_eq("wake_masked", 32'(wake), 32'd0);
    check_eq("wake_pending", 32'(pending[6]), 32'd1);
    src_en = 8'hff;
    tick();
    check_eq("wake_set", 32'(wake), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      reset  = ($urandom_range(0, 149) == 0);
      src    = NUM'($urandom & $urandom);
      src_en = ($urandom_range(0, 9) == 0) ? NUM'($urandom) : '1;
      if ($urandom_range(0, 99) == 0) src_edge = NUM'($urandom);
      halted = ($urandom_range(0, 15) == 0);
      fault  = ($urandom_range(0, 15) == 0);
      wfi    = 1'($urandom_range(0, 1));
      claim  = (m_state == M_ASSERT) ? ($urandom_range(0, 9) < 4)
                                     : ($urandom_range(0, 49) == 0);
      complete    = 1'b0;
      complete_id = IDW'($urandom_range(0, NUM - 1));
      if (m_state == M_SERVICE) begin
        if ($urandom_range(0, 9) < 3) begin
          complete    = 1'b1;
          complete_id = IDW'(m_insvc);
        end else if ($urandom_range(0, 29) == 0) begin
          complete = 1'b1;
        end
      end else begin
        complete = ($urandom_range(0, 49) == 0);
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
